conv_channel_injector: RTL
==========================

# conv_channel_injector

Parametrised channel-impairment stage between the convolutional encoder and the Viterbi decoder in the tx/rx harness. Registers each encoder output symbol (SYM_W bits, code rate 1/SYM_W), optionally flips selected bits with a deterministic periodic-burst pattern or a pseudo-random pattern, and forwards the symbol to the decoder with a one-cycle latency. Keeps saturating statistics (symbols seen, symbols corrupted) over a programmable measurement window, so the bench can check decoder correction capability against a known injected error count.

## Interface
Parameters:
- SYM_W, 2, symbol width (encoder outputs per input bit)
- CNT_W, 8, width of the period/phase counter and the burst configuration fields
- STAT_W, 16, width of the statistics counters
- LFSR_SEED, 16'hACE1, LFSR reset/clear value; must be non-zero

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cfg_mode_i  in  2  0 = pass, 1 = periodic burst, 2 = random, 3 = treated as 0
- cfg_period_i  in  CNT_W  burst period P in symbols; 0 means 2^CNT_W
- cfg_start_i  in  CNT_W  first phase of the burst inside the period
- cfg_len_i  in  CNT_W  burst length in symbols; 0 means no injection
- cfg_mask_i  in  SYM_W  bits XORed into a corrupted symbol
- cfg_thresh_i  in  8  random mode: inject when lfsr[7:0] < thresh
- cfg_limit_i  in  STAT_W  window length in symbols; 0 means unlimited
- clear_i  in  1  synchronous clear of phase, statistics, and LFSR
- valid_i  in  1  sym_i carries a symbol this cycle
- sym_i  in  SYM_W  encoder symbol
- valid_o  out  1  registered valid_i
- sym_o  out  SYM_W  possibly corrupted symbol; 0 when valid_o = 0
- err_o  out  1  the symbol on sym_o was corrupted
- sym_count_o  out  STAT_W  valid symbols accepted, saturating
- inj_count_o  out  STAT_W  corrupted symbols, saturating
- window_done_o  out  1  cfg_limit_i != 0 and sym_count_o >= cfg_limit_i

## Operation
- The phase counter advances only on valid_i, in every mode. It counts 0..P-1, then wraps to 0.
- Periodic mode: hit = (phase >= start) && (phase < start + len). Compute the sum in CNT_W+1 bits. A burst does not wrap past P-1, and phases >= P never occur.
- Random mode: a 16-bit Galois LFSR with taps 16'hB400 advances on each valid_i. hit = lfsr[7:0] < cfg_thresh_i, evaluated on the value before the advance.
- inject = valid_i && hit && in_window && (cfg_mask_i != 0), where in_window = (cfg_limit_i == 0) || (sym_count < cfg_limit_i).
- sym_o <= sym_i ^ (inject ? cfg_mask_i : 0). err_o <= inject.
- sym_count increments on each valid_i. inj_count increments on each inject. Both hold at all-ones.
- Configuration inputs are sampled on each valid symbol. A change takes effect on the next valid symbol. A mode change does not reset the phase or the LFSR.
- clear_i:
  - Sets phase = 0, both counts = 0, lfsr = LFSR_SEED.
  - If valid_i is high in the same cycle, the symbol passes through uncorrupted, err_o = 0, and it is not counted.

## Timing
- Latency is 1 cycle from valid_i/sym_i to valid_o/sym_o/err_o. Throughput is one symbol per cycle. There is no backpressure.
- Counters update on the same edge as sym_o. window_done_o is combinational from the registered sym_count and cfg_limit_i.
- Reset values: valid_o, sym_o, err_o, sym_count_o, inj_count_o, window_done_o = 0; phase = 0; lfsr = LFSR_SEED.
- Reset mid-stream discards the in-flight symbol. The first valid symbol after reset sees phase 0.

## Configuration
- INJ_RANDOM_EN defined: the LFSR and random mode are compiled in.
- INJ_RANDOM_EN undefined: the LFSR is removed, cfg_mode_i = 2 behaves as pass (inject = 0), and cfg_thresh_i is ignored.

## Test plan
- Mode 1, P=16, start=8, len=2, mask=2'b01, limit=256, 300 valid symbols of 2'b11:
  - sym_o = 2'b10 at phases 8 and 9 of each period, 2'b11 elsewhere.
  - After the run: inj_count_o = 32, sym_count_o = 300, window_done_o = 1.
- Mode 0, 100 random symbols: sym_o equals sym_i delayed by 1 cycle, err_o is never 1, inj_count_o = 0.
- valid_i toggling 1,0,1,0 in mode 1 with P=4, start=1, len=1:
  - Only the 2nd valid symbol is corrupted. Idle cycles do not advance the phase.
  - sym_o = 0 while valid_o = 0.
- clear_i asserted together with valid_i on a burst-phase symbol:
  - That symbol is not corrupted.
  - Next cycle: counts = 0. The next valid symbol uses phase 0.
- Mode 2 (INJ_RANDOM_EN defined), thresh=0 then thresh=255, 1000 symbols each:
  - thresh=0: inj_count_o = 0.
  - thresh=255: corruptions match a reference-model LFSR from seed 16'hACE1.
- Async reset asserted mid-burst with limit=0 and a 2^STAT_W+5 symbol run:
  - During reset all outputs are 0.
  - After reset the run restarts at phase 0, and sym_count_o saturates at all-ones.

Source files
------------

// File: rtl/conv_channel_injector.sv
// Channel impairment stage: registers encoder symbols and flips masked bits in periodic bursts or
// pseudo-random positions, with saturating window statistics. Define INJ_RANDOM_EN to build random mode.
module conv_channel_injector #(
    parameter int          SYM_W     = 2,
    parameter int          CNT_W     = 8,
    parameter int          STAT_W    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode_i,
    input  logic [CNT_W-1:0]  cfg_period_i,
    input  logic [CNT_W-1:0]  cfg_start_i,
    input  logic [CNT_W-1:0]  cfg_len_i,
    input  logic [SYM_W-1:0]  cfg_mask_i,
    input  logic [7:0]        cfg_thresh_i,
    input  logic [STAT_W-1:0] cfg_limit_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [SYM_W-1:0]  sym_i,
    output logic              valid_o,
    output logic [SYM_W-1:0]  sym_o,
    output logic              err_o,
    output logic [STAT_W-1:0] sym_count_o,
    output logic [STAT_W-1:0] inj_count_o,
    output logic              window_done_o
);

    localparam logic [1:0] MODE_BURST  = 2'd1;
    localparam logic [1:0] MODE_RANDOM = 2'd2;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

    logic              valid_q, valid_d;
    logic [SYM_W-1:0]  sym_q, sym_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  phase_q, phase_d;
    logic [STAT_W-1:0] sym_count_q, sym_count_d;
    logic [STAT_W-1:0] inj_count_q, inj_count_d;

    logic [CNT_W-1:0]  period_m1;
    logic [CNT_W:0]    burst_end;
    logic              burst_hit;
    logic              rand_hit;
    logic              hit;
    logic              in_window;
    logic              inject;

    // A period of 0 wraps to all-ones, so the counter simply rolls over at 2^CNT_W.
    assign period_m1 = cfg_period_i - {{(CNT_W-1){1'b0}}, 1'b1};
    assign burst_end = {1'b0, cfg_start_i} + {1'b0, cfg_len_i};
    assign burst_hit = ({1'b0, phase_q} >= {1'b0, cfg_start_i}) && ({1'b0, phase_q} < burst_end);

`ifdef INJ_RANDOM_EN
    logic [15:0] lfsr_q, lfsr_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    assign rand_hit = lfsr_q[7:0] < cfg_thresh_i;

    always_comb begin
        lfsr_d = lfsr_q;
        if (clear_i)      lfsr_d = LFSR_SEED;
        else if (valid_i) lfsr_d = lfsr_step(lfsr_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= LFSR_SEED;
        else      lfsr_q <= lfsr_d;
    end
`else
    logic unused_rand_cfg;
    assign unused_rand_cfg = ^{cfg_thresh_i, LFSR_SEED};
    assign rand_hit = 1'b0;
`endif

    always_comb begin
        case (cfg_mode_i)
            MODE_BURST:  hit = burst_hit;
            MODE_RANDOM: hit = rand_hit;
            default:     hit = 1'b0;
        endcase
    end

    assign in_window = (cfg_limit_i == '0) || (sym_count_q < cfg_limit_i);
    assign inject    = valid_i && !clear_i && hit && in_window && (|cfg_mask_i);

    always_comb begin
        valid_d     = valid_i;
        sym_d       = '0;
        err_d       = inject;
        phase_d     = phase_q;
        sym_count_d = sym_count_q;
        inj_count_d = inj_count_q;
        if (valid_i) sym_d = sym_i ^ (inject ? cfg_mask_i : '0);
        if (clear_i) begin
            phase_d     = '0;
            sym_count_d = '0;
            inj_count_d = '0;
        end else if (valid_i) begin
            phase_d     = (phase_q >= period_m1) ? '0 : phase_q + {{(CNT_W-1){1'b0}}, 1'b1};
            sym_count_d = sat_inc(sym_count_q);
            if (inject) inj_count_d = sat_inc(inj_count_q);
        end
    end

    // Output register stage: symbol, error flag and statistics update on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            sym_q       <= '0;
            err_q       <= 1'b0;
            phase_q     <= '0;
            sym_count_q <= '0;
            inj_count_q <= '0;
        end else begin
            valid_q     <= valid_d;
            sym_q       <= sym_d;
            err_q       <= err_d;
            phase_q     <= phase_d;
            sym_count_q <= sym_count_d;
            inj_count_q <= inj_count_d;
        end
    end

    assign valid_o       = valid_q;
    assign sym_o         = sym_q;
    assign err_o         = err_q;
    assign sym_count_o   = sym_count_q;
    assign inj_count_o   = inj_count_q;
    assign window_done_o = (cfg_limit_i != '0) && (sym_count_q >= cfg_limit_i);

endmodule
